// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encodings and default timing constants for stopwatch_ctrl
package stopwatch_pkg;

    // ST_BAD is never entered; it exists so the FSM can name and recover from it.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_BAD   = 2'd3
    } sw_state_t;

    localparam int DEF_TICK_DIV = 100000;
    localparam int DEF_DEB_CYC  = 20000;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - push-button synchroniser, debouncer and rising-edge press pulse
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-low reset
//   raw   - asynchronous button input, active-high
//   pulse - one-cycle pulse on each debounced 0->1 transition
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEB_CYC = DEF_DEB_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);

    localparam int              CW       = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CYC - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    // cnt counts consecutive cycles where the synchronised input disagrees
    // with the debounced level; any agreeing cycle restarts the count.
    // The pulse is registered on the same edge the level rises, so a clean
    // step reaches pulse DEB_CYC+2 cycles after it is applied.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            pulse <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync2;
                pulse <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch control FSM with debounced buttons and tick prescaler
//
// Ports:
//   clk                    - system clock, rising edge
//   rst                    - asynchronous active-low reset
//   start, stop, inc, lap  - raw push-buttons, active-high
//   tick                   - one-cycle pulse, counter advances by one
//   inc_pulse              - one-cycle pulse, manual counter increment
//   clr                    - one-cycle pulse, counter clears to zero
//   freeze                 - level, display holds while counter runs
//   st                     - FSM state (0 IDLE, 1 RUN, 2 PAUSE)
//
// Build option: STOPWATCH_LAP_EN enables the lap button and freeze output.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int DEB_CYC  = DEF_DEB_CYC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       inc,
    input  logic       lap,
    output logic       tick,
    output logic       inc_pulse,
    output logic       clr,
    output logic       freeze,
    output logic [1:0] st
);

    localparam int            PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    sw_state_t     state_q;
    sw_state_t     state_d;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          tick_d;
    logic          inc_d;
    logic          clr_d;
    logic          start_p;
    logic          stop_p;
    logic          inc_p;

    btn_debounce #(.DEB_CYC(DEB_CYC)) u_start (.clk(clk), .rst(rst), .raw(start), .pulse(start_p));
    btn_debounce #(.DEB_CYC(DEB_CYC)) u_stop  (.clk(clk), .rst(rst), .raw(stop),  .pulse(stop_p));
    btn_debounce #(.DEB_CYC(DEB_CYC)) u_inc   (.clk(clk), .rst(rst), .raw(inc),   .pulse(inc_p));

    // Stop is tested before start everywhere so a simultaneous press acts as stop.
    // The prescaler only moves while RUN and is left alone in PAUSE so a
    // resumed run finishes the partial tick period it was interrupted in.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        inc_d   = 1'b0;
        clr_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                inc_d = inc_p;
                if (!stop_p && start_p) begin
                    state_d = ST_RUN;
                    presc_d = '0;
                end
            end
            ST_RUN: begin
                if (stop_p) begin
                    state_d = ST_PAUSE;
                end
                if (presc_q == PRE_LAST) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            ST_PAUSE: begin
                inc_d = inc_p;
                if (stop_p) begin
                    state_d = ST_IDLE;
                    clr_d   = 1'b1;
                end else if (start_p) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            tick      <= 1'b0;
            inc_pulse <= 1'b0;
            clr       <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            tick      <= tick_d;
            inc_pulse <= inc_d;
            clr       <= clr_d;
        end
    end

    assign st = state_q;

`ifdef STOPWATCH_LAP_EN
    logic lap_p;
    logic frz_q;
    logic frz_d;

    btn_debounce #(.DEB_CYC(DEB_CYC)) u_lap (.clk(clk), .rst(rst), .raw(lap), .pulse(lap_p));

    // Leaving RUN always releases the display, even if lap fires on that edge.
    always_comb begin
        frz_d = frz_q;
        if (state_q == ST_RUN) begin
            if (state_d != ST_RUN) begin
                frz_d = 1'b0;
            end else if (lap_p) begin
                frz_d = ~frz_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frz_q <= 1'b0;
        end else begin
            frz_q <= frz_d;
        end
    end

    assign freeze = frz_q;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign freeze     = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - self-checking bench for stopwatch_ctrl (TICK_DIV=10, DEB_CYC=4)
module tb_stopwatch_ctrl;

    localparam int TICK_DIV = 10;
    localparam int DEB_CYC  = 4;
    localparam int NV       = 22;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       start = 1'b0;
    logic       stop  = 1'b0;
    logic       inc   = 1'b0;
    logic       lap   = 1'b0;
    logic       tick;
    logic       inc_pulse;
    logic       clr;
    logic       freeze;
    logic [1:0] st;

    stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .DEB_CYC(DEB_CYC)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .inc(inc), .lap(lap),
        .tick(tick), .inc_pulse(inc_pulse), .clr(clr), .freeze(freeze), .st(st)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cnt_clr = 0;
    int cnt_inc = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model. Button index: 0 start, 1 stop, 2 inc, 3 lap.
    // A debounced level flips when the last DEB_CYC synchronised samples
    // (raw input seen two edges earlier) all disagree with it.
    int  m_st, m_run, hist_n, nst;
    bit  m_tick, m_inc, m_clr, m_frz, flip;
    bit  m_lvl [4];
    bit  m_pulse [4];
    bit  raw_v [4];
    bit  hist [4][DEB_CYC+2];

    task automatic model_step();
        raw_v = '{start, stop, inc, lap};
        if (!rst) begin
            m_st = 0; m_run = 0; m_tick = 0; m_inc = 0; m_clr = 0; m_frz = 0;
            hist_n = 2;
            for (int b = 0; b < 4; b++) begin
                m_lvl[b] = 0;
                m_pulse[b] = 0;
                for (int i = 0; i < DEB_CYC + 2; i++) hist[b][i] = 0;
            end
        end else begin
            nst = m_st;
            if (m_pulse[1]) nst = (m_st == 1) ? 2 : 0;
            else if (m_pulse[0]) nst = 1;
            m_tick = 0;
            if (m_st == 1) begin
                m_run++;
                m_tick = (m_run % TICK_DIV) == 0;
            end else if (m_st == 0 && nst == 1) begin
                m_run = 0;
            end
            m_inc = m_pulse[2] && (m_st != 1);
            m_clr = (m_st == 2) && (nst == 0);
            if (LAP_EN && m_st == 1) m_frz = (nst != 1) ? 1'b0 : (m_frz ^ m_pulse[3]);
            m_st = nst;
            if (hist_n < 1000) hist_n++;
            for (int b = 0; b < 4; b++) begin
                for (int i = 0; i < DEB_CYC + 1; i++) hist[b][i] = hist[b][i+1];
                hist[b][DEB_CYC+1] = raw_v[b];
                flip = (hist_n >= DEB_CYC + 2);
                for (int i = 0; i < DEB_CYC; i++) if (hist[b][i] == m_lvl[b]) flip = 0;
                m_pulse[b] = flip && !m_lvl[b];
                if (flip) m_lvl[b] = !m_lvl[b];
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (clr) cnt_clr++;
        if (inc_pulse) cnt_inc++;
        if (!rst)
            chk("reset_outputs", int'({st, tick, inc_pulse, clr, freeze}), 0);
        else
            chk("model_outputs", int'({st, tick, inc_pulse, clr, freeze}),
                m_st * 16 + int'(m_tick) * 8 + int'(m_inc) * 4 + int'(m_clr) * 2 + int'(m_frz));
    end

    typedef struct {
        logic [3:0] btn;
        int         exp_st;
        int         exp_clr;
        int         exp_inc;
        int         exp_frz;
    } vec_t;

    vec_t tbl [NV];
    int   ticks [$];
    int   exp_ticks [5] = '{17, 27, 54, 64, 74};
    int   t_run1, t_pause, t_run2, clr_at, n_clr, late_tick, c0, i0;
    logic [3:0] btn_v;

    initial begin
        // {lap, inc, stop, start}
        tbl[0]  = '{4'h1, 1, 0, 0, 0};
        tbl[1]  = '{4'h4, 1, 0, 0, 0};
        tbl[2]  = '{4'h2, 2, 0, 0, 0};
        tbl[3]  = '{4'h4, 2, 0, 1, 0};
        tbl[4]  = '{4'h4, 2, 0, 1, 0};
        tbl[5]  = '{4'h4, 2, 0, 1, 0};
        tbl[6]  = '{4'h3, 0, 1, 0, 0};
        tbl[7]  = '{4'h3, 0, 0, 0, 0};
        tbl[8]  = '{4'h2, 0, 0, 0, 0};
        tbl[9]  = '{4'h4, 0, 0, 1, 0};
        tbl[10] = '{4'h1, 1, 0, 0, 0};
        tbl[11] = '{4'h1, 1, 0, 0, 0};
        tbl[12] = '{4'h3, 2, 0, 0, 0};
        tbl[13] = '{4'h1, 1, 0, 0, 0};
        tbl[14] = '{4'h8, 1, 0, 0, int'(LAP_EN)};
        tbl[15] = '{4'h8, 1, 0, 0, 0};
        tbl[16] = '{4'h8, 1, 0, 0, int'(LAP_EN)};
        tbl[17] = '{4'h2, 2, 0, 0, 0};
        tbl[18] = '{4'h1, 1, 0, 0, 0};
        tbl[19] = '{4'h2, 2, 0, 0, 0};
        tbl[20] = '{4'h2, 0, 1, 0, 0};
        tbl[21] = '{4'h8, 0, 0, 0, 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_st", int'(st), 0);
        chk("reset_freeze", int'(freeze), 0);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);

        // Timeline: start step after edge 0, stop/start/stop presses at fixed cycles.
        t_run1 = -1; t_pause = -1; t_run2 = -1; clr_at = -1; n_clr = 0; late_tick = 0;
        @(posedge clk);
        #1 start = 1'b1;
        for (int c = 1; c <= 130; c++) begin
            @(posedge clk);
            #1;
            case (c)
                12:  start = 1'b0;
                23:  stop  = 1'b1;
                32:  stop  = 1'b0;
                40:  start = 1'b1;
                50:  start = 1'b0;
                70:  stop  = 1'b1;
                80:  stop  = 1'b0;
                90:  stop  = 1'b1;
                100: stop  = 1'b0;
                default: ;
            endcase
            @(negedge clk);
            if (t_run1 < 0 && st == 2'd1) t_run1 = c;
            if (t_run1 >= 0 && t_pause < 0 && st == 2'd2) t_pause = c;
            if (t_pause >= 0 && t_run2 < 0 && st == 2'd1) t_run2 = c;
            if (tick && clr_at >= 0) late_tick++;
            if (tick) ticks.push_back(c);
            if (clr) begin
                n_clr++;
                clr_at = c;
            end
        end
        chk("run_entry_cycle", t_run1, 7);
        chk("pause_entry_cycle", t_pause, 30);
        chk("resume_entry_cycle", t_run2, 47);
        chk("tick_count", ticks.size(), 5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("tick_cycle_%0d", i), (i < ticks.size()) ? ticks[i] : -1, exp_ticks[i]);
        chk("clr_pulses", n_clr, 1);
        chk("clr_cycle", clr_at, 97);
        chk("tick_after_clr", late_tick, 0);
        chk("final_st", int'(st), 0);

        // Table of single presses with settled expectations.
        for (int i = 0; i < NV; i++) begin
            c0 = cnt_clr;
            i0 = cnt_inc;
            @(posedge clk);
            #1 {lap, inc, stop, start} = tbl[i].btn;
            repeat (DEB_CYC + 4) @(posedge clk);
            #1 {lap, inc, stop, start} = 4'h0;
            repeat (DEB_CYC + 4) @(posedge clk);
            @(negedge clk);
            chk($sformatf("row%0d_st", i), int'(st), tbl[i].exp_st);
            chk($sformatf("row%0d_clr", i), cnt_clr - c0, tbl[i].exp_clr);
            chk($sformatf("row%0d_inc", i), cnt_inc - i0, tbl[i].exp_inc);
            chk($sformatf("row%0d_freeze", i), int'(freeze), tbl[i].exp_frz);
        end

        // Reset in RUN (with freeze set when lap exists), then a short glitch.
        @(posedge clk);
        #1 start = 1'b1;
        repeat (DEB_CYC + 4) @(posedge clk);
        #1 start = 1'b0;
        repeat (DEB_CYC + 4) @(posedge clk);
        #1 lap = 1'b1;
        repeat (DEB_CYC + 4) @(posedge clk);
        #1 lap = 1'b0;
        repeat (DEB_CYC + 4) @(posedge clk);
        @(negedge clk);
        chk("pre_reset_st", int'(st), 1);
        chk("pre_reset_freeze", int'(freeze), int'(LAP_EN));
        #1 rst = 1'b0;
        #1;
        chk("async_rst_st", int'(st), 0);
        chk("async_rst_flags", int'({tick, inc_pulse, clr, freeze}), 0);
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 start = 1'b1;
        repeat (2) @(posedge clk);
        #1 start = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("glitch_no_run", int'(st), 0);

        // Random buttons and occasional resets against the model.
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk);
            #1;
            if (!rst) rst = 1'b1;
            else if ($urandom_range(0, 499) == 0) rst = 1'b0;
            btn_v = {lap, inc, stop, start};
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 7) == 0) btn_v[b] = ~btn_v[b];
            {lap, inc, stop, start} = btn_v;
        end
        #1 {lap, inc, stop, start} = 4'h0;
        rst = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 100000, clk cycles per count tick; minimum 2.
REQ-002 Parameter DEB_CYC, default 20000, consecutive stable cycles for a debounced level change; minimum 1.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start, stop, inc, lap  input  1 each  raw asynchronous push-buttons, active-high.
REQ-006 tick  output  1  one-cycle pulse: counter advances by one.
REQ-007 inc_pulse  output  1  one-cycle pulse: manual counter increment.
REQ-008 clr  output  1  one-cycle pulse: counter clears to zero.
REQ-009 freeze  output  1  level: display holds its last value while the counter keeps running.
REQ-010 st  output  2  current FSM state encoding.

Function
REQ-011 Each button passes through a 2-FF synchroniser, then a debouncer; the debounced level changes only after DEB_CYC consecutive cycles of a differing synchronised value.
REQ-012 A press pulse is one cycle on each debounced 0->1 edge; a raw step held stable yields its pulse exactly DEB_CYC+2 cycles after the step.
REQ-013 FSM states: IDLE=0, RUN=1, PAUSE=2; encoding 3 is unreachable and recovers to IDLE on the next edge.
REQ-014 Transitions: IDLE+start->RUN; RUN+stop->PAUSE; PAUSE+start->RUN; PAUSE+stop->IDLE with clr; all other presses ignored.
REQ-015 Simultaneous start and stop pulses in one cycle: stop wins.
REQ-016 st updates on the edge that samples the press pulse; clr, inc_pulse and tick are registered, one cycle each.
REQ-017 inc press in IDLE or PAUSE produces inc_pulse one cycle later; ignored in RUN.
REQ-018 Prescaler, width $clog2(TICK_DIV), counts only in RUN; on value TICK_DIV-1 it wraps to 0 and tick pulses in the following cycle.
REQ-019 Prescaler clears to 0 on IDLE->RUN; it holds its value across RUN->PAUSE->RUN.
REQ-020 tick and inc_pulse are never high in the same cycle.

Reset
REQ-021 rst low asynchronously forces st=IDLE, prescaler=0, debouncer levels and counters=0, synchronisers=0, and tick=inc_pulse=clr=freeze=0.
REQ-022 Reset release mid-press produces no pulse until a fresh debounced 0->1 edge occurs.

Configuration
REQ-023 Macro STOPWATCH_LAP_EN defined: a lap press in RUN toggles freeze; any exit from RUN clears freeze in the same edge.
REQ-024 Macro STOPWATCH_LAP_EN undefined: the lap port remains, is ignored, freeze is tied 0, and no lap debouncer is built.

Structure
REQ-025 Package stopwatch_pkg holds the state encodings and the default TICK_DIV and DEB_CYC constants.
REQ-026 Sub-module btn_debounce (synchroniser, debouncer, edge pulse; parameter DEB_CYC) is instantiated once per button.

Verification (bench: TICK_DIV=10, DEB_CYC=4)
REQ-027 start raised and held from IDLE -> pulse 6 cycles later, st=1 next edge, first tick 10 cycles after entry, then every 10 cycles.
REQ-028 RUN, stop after 3 prescaler counts, then start -> st 1->2->1; first tick after resume arrives 7 cycles after RUN re-entry.
REQ-029 PAUSE, stop press -> st=0 and clr high exactly one cycle; no tick afterwards.
REQ-030 start and stop raised on the same cycle in IDLE -> st stays 0; in RUN -> st=2.
REQ-031 inc pressed 3 times in PAUSE -> 3 inc_pulse; inc pressed in RUN -> none.
REQ-032 rst low mid-RUN with a 2-cycle button glitch -> all outputs 0 immediately; glitch yields no pulse; with STOPWATCH_LAP_EN, lap in RUN -> freeze=1, then stop -> freeze=0.
